// File: rtl/lupdate_rx.sv
// Beacon update receiver: strips CNC beacon-update packets from the 134-bit stream,
// commits their beat-6 fields to the config outputs and forwards everything else 3 cycles later.
module lupdate_rx #(
  parameter logic [47:0] CNC_MAC  = 48'h010203040506,
  parameter logic [3:0]  UPD_TYPE = 4'hf,
  parameter logic        DEF_DIR  = 1'b0,
  parameter logic [31:0] DEF_TBP  = 32'd0,
  parameter logic [47:0] DEF_DMAC = 48'd0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_data_wr,
  input  logic [133:0] in_data,
  input  logic         in_data_valid,
  input  logic         in_data_valid_wr,
  input  logic [47:0]  in_local_mac_id,
  output logic         out_data_wr,
  output logic [133:0] out_data,
  output logic         out_data_valid,
  output logic         out_data_valid_wr,
  output logic         direction,
  output logic [31:0]  token_bucket_para,
  output logic [47:0]  direct_mac_addr,
  output logic [31:0]  upd_cnt,
  output logic [15:0]  upd_err_cnt
);

  typedef enum logic [1:0] {IDLE, HDR, FWD, DROP} state_t;

  typedef struct packed {
    logic         wr;
    logic [133:0] data;
    logic         valid;
    logic         valid_wr;
    logic         drop;
  } stage_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        sh_dir;
  logic [31:0] sh_tbp;
  logic [47:0] sh_dmac;

  stage_t st_p0, st_p1, st_p2;
  // hd marks beats of the packet whose header is still being inspected
  logic   hd_p0, hd_p1;

  logic       is_head, is_tail, match, hit, drop_in, hd_in;
  logic [3:0] idx;

  assign is_head = in_data_wr && (in_data[133:132] == 2'b01);
  assign is_tail = in_data_wr && (in_data[133:132] == 2'b10);
  assign idx     = (cnt == 4'hf) ? 4'hf : cnt + 4'd1;
  assign match   = (in_data[127:80] == in_local_mac_id) && (in_data[79:32] == CNC_MAC) &&
                   (in_data[31:16] == 16'h88f7) && (in_data[11:8] == UPD_TYPE);
  assign hit     = in_data_wr && !is_head && (state == HDR) && (idx >= 4'd2) && match;
  assign drop_in = hit || ((state == DROP) && !is_head);
  assign hd_in   = is_head || (in_data_wr && (state == HDR));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      cnt               <= 4'd0;
      sh_dir            <= 1'b0;
      sh_tbp            <= 32'd0;
      sh_dmac           <= 48'd0;
      direction         <= DEF_DIR;
      token_bucket_para <= DEF_TBP;
      direct_mac_addr   <= DEF_DMAC;
      upd_cnt           <= 32'd0;
      upd_err_cnt       <= 16'd0;
    end else if (in_data_wr) begin
      if (is_head) begin
        state <= HDR;
        cnt   <= 4'd0;
      end else begin
        cnt <= idx;
        case (state)
          IDLE: state <= IDLE;
          HDR: begin
            if (idx >= 4'd2) begin
              if (match) begin
                if (is_tail) begin
                  state <= IDLE;
                  if (upd_err_cnt != 16'hffff) upd_err_cnt <= upd_err_cnt + 16'd1;
                end else begin
                  state <= DROP;
                end
              end else begin
                state <= is_tail ? IDLE : FWD;
              end
            end else if (is_tail) begin
              state <= IDLE;
            end
          end
          FWD: if (is_tail) state <= IDLE;
          DROP: begin
            if (idx == 4'd6) begin
              sh_dmac <= in_data[127:80];
              sh_dir  <= in_data[79];
              sh_tbp  <= in_data[63:32];
            end
            if (is_tail) begin
              state <= IDLE;
              // a tail that is itself beat 6 commits straight from the bus
              if (idx >= 4'd6) begin
                direct_mac_addr   <= (idx == 4'd6) ? in_data[127:80] : sh_dmac;
                direction         <= (idx == 4'd6) ? in_data[79]     : sh_dir;
                token_bucket_para <= (idx == 4'd6) ? in_data[63:32]  : sh_tbp;
                upd_cnt           <= upd_cnt + 32'd1;
              end else if (upd_err_cnt != 16'hffff) begin
                upd_err_cnt <= upd_err_cnt + 16'd1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // stage p0 -> p1 -> p2; a header match retro-marks the header beats still in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_p0 <= '0;
      st_p1 <= '0;
      st_p2 <= '0;
      hd_p0 <= 1'b0;
      hd_p1 <= 1'b0;
    end else begin
      st_p0      <= {in_data_wr, in_data, in_data_valid, in_data_valid_wr, drop_in};
      hd_p0      <= hd_in;
      st_p1      <= st_p0;
      st_p1.drop <= st_p0.drop | (hit & hd_p0);
      hd_p1      <= hd_p0 & ~is_head;
      st_p2      <= st_p1;
      st_p2.drop <= st_p1.drop | (hit & hd_p1);
    end
  end

  assign out_data_wr       = st_p2.wr & ~st_p2.drop;
  assign out_data          = out_data_wr ? st_p2.data : 134'd0;
  assign out_data_valid    = st_p2.valid;
  assign out_data_valid_wr = st_p2.valid_wr & ~st_p2.drop;

endmodule
